// File: rtl/spectrum_frame_buffer_pkg.sv
// ============================================================================
// Module  : spectrum_pkg
// Brief   : Shared constants, types and helpers for the spectrum frame buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spectrum_pkg;

  localparam int N_POINTS   = 256;
  localparam int ADDR_W     = 8;
  localparam int HEIGHT_W   = 10;
  localparam int BAR_MAX    = 480;
  localparam int PIPE_DEPTH = 3;
  localparam int MAG_W      = 17;

  // End-of-run marker travelling alongside the magnitude pipeline
  typedef struct packed {
    logic last;
    logic ok;
  } run_evt_t;

  // 17-bit result keeps |-32768| = 32768 representable
  function automatic logic [MAG_W-1:0] abs16(input logic [15:0] v);
    logic [MAG_W-1:0] ext;
    ext = {v[15], v};
    return v[15] ? (~ext + MAG_W'(1)) : ext;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spectrum_frame_buffer_if.sv
// ============================================================================
// Module  : spectrum_frame_buffer_if
// Brief   : FFT input stream, display read port and status pulses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface spectrum_frame_buffer_if #(
  parameter int ADDR_W   = 8,
  parameter int HEIGHT_W = 10
);
  logic [31:0]         fft_data;
  logic                data_valid;
  logic                frame_sync;
  logic [ADDR_W-1:0]   rd_addr;
  logic [HEIGHT_W-1:0] rd_data;
  logic                bank_sel;
  logic                frame_done;
  logic                frame_err;
  logic                swap_pulse;

  modport master (
    output fft_data, data_valid, frame_sync, rd_addr,
    input  rd_data, bank_sel, frame_done, frame_err, swap_pulse
  );

  modport slave (
    input  fft_data, data_valid, frame_sync, rd_addr,
    output rd_data, bank_sel, frame_done, frame_err, swap_pulse
  );
endinterface

`default_nettype wire

// File: rtl/spectrum_mag_est.sv
// ============================================================================
// Module  : spectrum_mag_est
// Brief   : 3-stage alpha-max-beta-min magnitude to saturated bar height.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spectrum_mag_est #(
  parameter int ADDR_W   = 8,
  parameter int HEIGHT_W = 10,
  parameter int BAR_MAX  = 480,
  parameter int SHIFT    = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   idx_i,
  input  logic [31:0]         data_i,
  output logic                valid_o,
  output logic [ADDR_W-1:0]   idx_o,
  output logic [HEIGHT_W-1:0] height_o
);
  import spectrum_pkg::*;

  logic [MAG_W-1:0]    abs_re_q, abs_im_q, abs_re_d, abs_im_d;
  logic [MAG_W-1:0]    mag_q, mag_d;
  logic [HEIGHT_W-1:0] height_q, height_d;
  logic                v1_q, v2_q, v3_q;
  logic [ADDR_W-1:0]   idx1_q, idx2_q, idx3_q;

  logic [MAG_W-1:0]    w_max, w_min, w_shift;

  always_comb begin
    abs_re_d = abs16(data_i[15:0]);
    abs_im_d = abs16(data_i[31:16]);

    w_max = (abs_re_q >= abs_im_q) ? abs_re_q : abs_im_q;
    w_min = (abs_re_q >= abs_im_q) ? abs_im_q : abs_re_q;
    mag_d = w_max + (w_min >> 1);

    w_shift  = mag_q >> SHIFT;
    height_d = (w_shift > MAG_W'(BAR_MAX)) ? HEIGHT_W'(BAR_MAX) : w_shift[HEIGHT_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      abs_re_q <= '0;
      abs_im_q <= '0;
      mag_q    <= '0;
      height_q <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      idx1_q   <= '0;
      idx2_q   <= '0;
      idx3_q   <= '0;
    end else begin
      abs_re_q <= abs_re_d;
      abs_im_q <= abs_im_d;
      mag_q    <= mag_d;
      height_q <= height_d;
      v1_q     <= valid_i;
      v2_q     <= v1_q;
      v3_q     <= v2_q;
      idx1_q   <= idx_i;
      idx2_q   <= idx1_q;
      idx3_q   <= idx2_q;
    end
  end

  assign valid_o  = v3_q;
  assign idx_o    = idx3_q;
  assign height_o = height_q;

endmodule

`default_nettype wire

// File: rtl/spectrum_frame_buffer.sv
// ============================================================================
// Module  : spectrum_frame_buffer
// Brief   : Ping-pong bar-height store, swapped only at display frame sync.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spectrum_frame_buffer #(
  parameter int N_POINTS = spectrum_pkg::N_POINTS,
  parameter int ADDR_W   = spectrum_pkg::ADDR_W,
  parameter int HEIGHT_W = spectrum_pkg::HEIGHT_W,
  parameter int BAR_MAX  = spectrum_pkg::BAR_MAX,
  parameter int SHIFT    = 0
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  spectrum_frame_buffer_if.slave   fb_if
);
  import spectrum_pkg::*;

  localparam int CNT_W = ADDR_W + 1;

  logic [CNT_W-1:0]    wr_idx_q, wr_idx_d;
  logic                bad_q, bad_d;
  logic                pending_q, pending_d;
  logic                dv_q;
  logic                bank_sel_q;
  logic                swap_pulse_q;
  logic                frame_done_q;
  logic                frame_err_q;
  logic [HEIGHT_W-1:0] rd_data_q;
  run_evt_t [PIPE_DEPTH-1:0] evt_q;

  logic                w_in_range, w_wr_en, w_run_start, w_run_end;
  logic                w_commit, w_discard, w_swap;
  run_evt_t            w_evt;

  logic                mag_valid;
  logic [ADDR_W-1:0]   mag_idx;
  logic [HEIGHT_W-1:0] mag_height;

  logic [HEIGHT_W-1:0] mem [2*N_POINTS];

  assign w_in_range  = (wr_idx_q < CNT_W'(N_POINTS));
  assign w_wr_en     = fb_if.data_valid & w_in_range;
  assign w_run_start = fb_if.data_valid & ~dv_q;
  assign w_run_end   = ~fb_if.data_valid & dv_q;
  assign w_evt.last  = w_run_end;
  assign w_evt.ok    = (wr_idx_q == CNT_W'(N_POINTS)) & ~bad_q;

  // Verdict is delayed by the pipeline depth so it lands after the last write
  assign w_commit  = evt_q[PIPE_DEPTH-1].last &  evt_q[PIPE_DEPTH-1].ok;
  assign w_discard = evt_q[PIPE_DEPTH-1].last & ~evt_q[PIPE_DEPTH-1].ok;
  assign w_swap    = fb_if.frame_sync & pending_q;

  always_comb begin
    wr_idx_d  = wr_idx_q;
    bad_d     = bad_q;
    pending_d = pending_q;
    if (w_run_end) begin
      wr_idx_d = '0;
      bad_d    = 1'b0;
    end else if (fb_if.data_valid) begin
      if (w_in_range) begin
        wr_idx_d = wr_idx_q + CNT_W'(1);
      end else begin
        bad_d = 1'b1;
      end
    end
    // Later assignments take priority: a new run or a swap leaves pending clear
    if (w_commit)    pending_d = 1'b1;
    if (w_run_start) pending_d = 1'b0;
    if (w_swap)      pending_d = 1'b0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_idx_q     <= '0;
      bad_q        <= 1'b0;
      pending_q    <= 1'b0;
      dv_q         <= 1'b0;
      bank_sel_q   <= 1'b0;
      swap_pulse_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      evt_q        <= '0;
    end else begin
      wr_idx_q     <= wr_idx_d;
      bad_q        <= bad_d;
      pending_q    <= pending_d;
      dv_q         <= fb_if.data_valid;
      bank_sel_q   <= bank_sel_q ^ w_swap;
      swap_pulse_q <= w_swap;
      frame_done_q <= w_commit;
      frame_err_q  <= w_discard;
      evt_q        <= {evt_q[PIPE_DEPTH-2:0], w_evt};
    end
  end

  spectrum_mag_est #(
    .ADDR_W   (ADDR_W),
    .HEIGHT_W (HEIGHT_W),
    .BAR_MAX  (BAR_MAX),
    .SHIFT    (SHIFT)
  ) u_mag_est (
    .clk_i    (sys_clk),
    .rst_i    (sys_rst),
    .valid_i  (w_wr_en),
    .idx_i    (wr_idx_q[ADDR_W-1:0]),
    .data_i   (fb_if.fft_data),
    .valid_o  (mag_valid),
    .idx_o    (mag_idx),
    .height_o (mag_height)
  );

  // Bank picked at write time, so a swap racing a new run redirects it cleanly
  always_ff @(posedge sys_clk) begin
    if (mag_valid) begin
      mem[{~bank_sel_q, mag_idx}] <= mag_height;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[{bank_sel_q, fb_if.rd_addr}];
    end
  end

  assign fb_if.rd_data    = rd_data_q;
  assign fb_if.bank_sel   = bank_sel_q;
  assign fb_if.frame_done = frame_done_q;
  assign fb_if.frame_err  = frame_err_q;
  assign fb_if.swap_pulse = swap_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_spectrum_frame_buffer.sv
// ============================================================================
// Module  : tb_spectrum_frame_buffer
// Brief   : Directed self-checking bench; SHIFT=0 and SHIFT=2 instances.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spectrum_frame_buffer;

  logic sys_clk;
  logic sys_rst;

  int n_chk;
  int n_err;
  int n_done0, n_err0, n_swap0;

  spectrum_frame_buffer_if #(.ADDR_W(8), .HEIGHT_W(10)) bus0 ();
  spectrum_frame_buffer_if #(.ADDR_W(8), .HEIGHT_W(10)) bus1 ();

  assign bus1.fft_data   = bus0.fft_data;
  assign bus1.data_valid = bus0.data_valid;
  assign bus1.frame_sync = bus0.frame_sync;
  assign bus1.rd_addr    = bus0.rd_addr;

  spectrum_frame_buffer #(
    .N_POINTS(256), .ADDR_W(8), .HEIGHT_W(10), .BAR_MAX(480), .SHIFT(0)
  ) dut0 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .fb_if   (bus0)
  );

  spectrum_frame_buffer #(
    .N_POINTS(256), .ADDR_W(8), .HEIGHT_W(10), .BAR_MAX(480), .SHIFT(2)
  ) dut1 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .fb_if   (bus1)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    #2;
    if (bus0.frame_done === 1'b1) n_done0++;
    if (bus0.frame_err  === 1'b1) n_err0++;
    if (bus0.swap_pulse === 1'b1) n_swap0++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic drive_bin(input int re, input int im);
    bus0.fft_data   = {im[15:0], re[15:0]};
    bus0.data_valid = 1'b1;
    tick();
  endtask

  // mode 0: re=k  1: re=255-k  2: re=2k  3: re=7  4: magnitude corner cases
  task automatic send_frame(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      case (mode)
        0: drive_bin(k, 0);
        1: drive_bin(255 - k, 0);
        2: drive_bin(2 * k, 0);
        3: drive_bin(7, 0);
        default: begin
          case (k)
            0: drive_bin(-300, 200);
            1: drive_bin(32767, 0);
            2: drive_bin(-32768, -32768);
            3: drive_bin(1000, 0);
            default: drive_bin(0, 0);
          endcase
        end
      endcase
    end
    bus0.data_valid = 1'b0;
    bus0.fft_data   = '0;
  endtask

  task automatic pulse_sync();
    bus0.frame_sync = 1'b1;
    tick();
    bus0.frame_sync = 1'b0;
  endtask

  task automatic rd(input int a);
    bus0.rd_addr = a[7:0];
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_prev;
    int a;
    int d_snap;
    int e_snap;

    n_chk = 0; n_err = 0;
    n_done0 = 0; n_err0 = 0; n_swap0 = 0;
    bus0.fft_data = '0; bus0.data_valid = 1'b0; bus0.frame_sync = 1'b0; bus0.rd_addr = '0;
    sys_rst = 1'b0;
    #1 sys_rst = 1'b1;
    repeat (3) tick();

    check("rst_rd_data",  bus0.rd_data,    0);
    check("rst_bank_sel", bus0.bank_sel,   0);
    check("rst_done",     bus0.frame_done, 0);
    check("rst_err",      bus0.frame_err,  0);
    check("rst_swap",     bus0.swap_pulse, 0);
    sys_rst = 1'b0;
    tick();

    // Ramp frame with latency check on frame_done
    send_frame(256, 0);
    repeat (3) tick();
    check("done_before_lat", bus0.frame_done, 0);
    tick();
    check("done_at_lat4", bus0.frame_done, 1);
    tick();
    check("done_one_pulse", bus0.frame_done, 0);
    check("ramp_done_cnt", n_done0, 1);
    check("ramp_err_cnt",  n_err0,  0);
    check("ramp_no_early_swap", bus0.bank_sel, 0);
    pulse_sync();
    check("ramp_swap_pulse", bus0.swap_pulse, 1);
    check("ramp_bank_sel",   bus0.bank_sel,   1);
    tick();
    check("ramp_swap_cnt",   n_swap0, 1);
    rd(100);
    check("ramp_rd100",       bus0.rd_data, 100);
    check("ramp_rd100_shift", bus1.rd_data, 25);

    // Short run
    send_frame(255, 1);
    repeat (6) tick();
    check("short_err_cnt",  n_err0,  1);
    check("short_done_cnt", n_done0, 1);
    pulse_sync();
    tick();
    check("short_no_swap_cnt", n_swap0, 1);
    check("short_bank_sel",    bus0.bank_sel, 1);

    // Long run must leave the displayed bank intact
    send_frame(300, 3);
    repeat (6) tick();
    check("long_err_cnt", n_err0, 2);
    check("long_done_cnt", n_done0, 1);
    for (int i = 0; i < 256; i++) begin
      rd(i);
      check("long_disp_kept", bus0.rd_data, i);
    end

    // Overwrite: A committed, B follows after one idle cycle, B shown
    send_frame(256, 3);
    tick();
    send_frame(256, 1);
    repeat (6) tick();
    check("ovw_done_cnt", n_done0, 3);
    pulse_sync();
    check("ovw_bank_sel", bus0.bank_sel, 0);
    rd(0);
    check("ovw_rd0",   bus0.rd_data, 255);
    rd(10);
    check("ovw_rd10",  bus0.rd_data, 245);
    check("ovw_rd10_shift", bus1.rd_data, 61);
    rd(255);
    check("ovw_rd255", bus0.rd_data, 0);

    // Magnitude and saturation corners
    send_frame(256, 4);
    repeat (6) tick();
    check("mag_done_cnt", n_done0, 4);
    pulse_sync();
    check("mag_bank_sel", bus0.bank_sel, 1);
    rd(0);
    check("mag_m300_200",     bus0.rd_data, 400);
    check("mag_m300_200_sh2", bus1.rd_data, 100);
    rd(1);
    check("mag_32767_sat",     bus0.rd_data, 480);
    check("mag_32767_sat_sh2", bus1.rd_data, 480);
    rd(2);
    check("mag_m32768_sat",     bus0.rd_data, 480);
    check("mag_m32768_sat_sh2", bus1.rd_data, 480);
    rd(3);
    check("mag_1000_sat",  bus0.rd_data, 480);
    check("mag_1000_sh2",  bus1.rd_data, 250);
    rd(4);
    check("mag_zero",      bus0.rd_data, 0);

    // Commit and frame_sync in the same cycle: swap deferred
    send_frame(256, 0);
    repeat (3) tick();
    bus0.frame_sync = 1'b1;
    tick();
    bus0.frame_sync = 1'b0;
    check("race_done",     bus0.frame_done, 1);
    check("race_no_swap",  bus0.swap_pulse, 0);
    check("race_bank_kept", bus0.bank_sel,  1);
    tick();
    pulse_sync();
    check("race_late_swap", bus0.swap_pulse, 1);
    check("race_bank_sel",  bus0.bank_sel,   0);
    rd(100);
    check("race_rd100", bus0.rd_data, 100);

    // Tear-free reads while frame C is written and swapped in
    exp_prev = 0;
    for (int c = 0; c <= 270; c++) begin
      if (c > 0) check("tear_rd", bus0.rd_data, exp_prev);
      if (c == 263) check("tear_swap_pulse", bus0.swap_pulse, 1);
      if (c < 256) begin
        bus0.fft_data   = {16'd0, 16'(2 * c)};
        bus0.data_valid = 1'b1;
      end else begin
        bus0.fft_data   = '0;
        bus0.data_valid = 1'b0;
      end
      bus0.frame_sync = (c == 262);
      a = c % 256;
      bus0.rd_addr = a[7:0];
      if (c > 262) exp_prev = (2 * a > 480) ? 480 : 2 * a;
      else         exp_prev = a;
      tick();
    end
    bus0.frame_sync = 1'b0;
    check("tear_bank_sel", bus0.bank_sel, 1);
    rd(250);
    check("tear_sat_rd250", bus0.rd_data, 480);

    // Reset in the middle of a run
    d_snap = n_done0;
    e_snap = n_err0;
    for (int k = 0; k < 128; k++) drive_bin(k, 0);
    sys_rst = 1'b1;
    bus0.data_valid = 1'b0;
    tick();
    tick();
    check("mrst_rd_data",  bus0.rd_data,    0);
    check("mrst_bank_sel", bus0.bank_sel,   0);
    check("mrst_bank_sel1", bus1.bank_sel,  0);
    check("mrst_done",     bus0.frame_done, 0);
    check("mrst_err",      bus0.frame_err,  0);
    check("mrst_swap",     bus0.swap_pulse, 0);
    sys_rst = 1'b0;
    tick();
    send_frame(256, 2);
    repeat (6) tick();
    check("mrst_done_cnt", n_done0, d_snap + 1);
    check("mrst_no_err",   n_err0,  e_snap);
    pulse_sync();
    check("mrst_bank_sel_after", bus0.bank_sel, 1);
    rd(100);
    check("mrst_rd100",     bus0.rd_data, 200);
    check("mrst_rd100_sh2", bus1.rd_data, 50);
    rd(250);
    check("mrst_rd250",     bus0.rd_data, 480);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
